// File: rtl/rdmap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rdmap_pkg
// Description : Shared constants, rdmap command-word field offsets and the
//               DDR writer FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package rdmap_pkg;

  // AXI4 encodings used by the writer
  localparam logic [2:0] AXSIZE_16B = 3'b100;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Command word field offsets
  localparam int CMD_LEN_LSB   = 0;
  localparam int CMD_LEN_MSB   = 11;
  localparam int CMD_VALID_BIT = 31;
  localparam int CMD_IDX_LSB   = 24;
  localparam int CMD_IDX_MSB   = 29;
  localparam int CMD_BASE_LSB  = 30;
  localparam int CMD_BASE_MSB  = 43;

  // Writer FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AW   = 2'd1,
    W    = 2'd2,
    B    = 2'd3
  } wr_state_e;

endpackage : rdmap_pkg
`default_nettype wire

// File: rtl/rdmap_cmd_decode.sv
`default_nettype none
// ============================================================================
// Module      : rdmap_cmd_decode
// Description : Combinational decode of one rdmap command word into the AXI
//               burst address, AXI awlen and a legality flag.
// Ports       : i_cmd    - 64-bit command word
//               o_addr   - 4 KB aligned byte address
//               o_awlen  - beats - 1
//               o_legal  - valid marker set and length a whole number of beats
// Revision    : 1.0 - initial release
// ============================================================================
module rdmap_cmd_decode
  import rdmap_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [63:0]       i_cmd,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_awlen,
  output logic              o_legal
);

  logic [31:0] w_addr32;
  logic [12:0] w_bytes;
  logic [8:0]  w_beats;
  logic [8:0]  w_len9;
  logic        w_unused;

  // Base and chunk index concatenate directly into a 4 KB aligned address.
  assign w_addr32 = {i_cmd[CMD_BASE_MSB:CMD_BASE_LSB],
                     i_cmd[CMD_IDX_MSB:CMD_IDX_LSB], 12'h000};
  assign o_addr   = ADDR_W'(w_addr32);

  // Length field holds byte count - 1; a full 4 KB chunk gives 256 beats.
  assign w_bytes  = {1'b0, i_cmd[CMD_LEN_MSB:CMD_LEN_LSB]} + 13'd1;
  assign w_beats  = w_bytes[12:4];
  assign w_len9   = w_beats - 9'd1;
  assign o_awlen  = w_len9[7:0];

  // A partial trailing beat cannot be expressed with a full strobe.
  assign o_legal  = i_cmd[CMD_VALID_BIT] && (i_cmd[3:0] == 4'hF);

  assign w_unused = ^{i_cmd[63:44], w_bytes[3:0], w_len9[8]};

endmodule : rdmap_cmd_decode
`default_nettype wire

// File: rtl/rdmap_ddr_writer.sv
`default_nettype none
// ============================================================================
// Module      : rdmap_ddr_writer
// Description : Drains the rdmap command and write-data FIFOs, issuing one
//               AXI4 INCR write burst per command with a single burst in
//               flight, and reports completion / error status.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               cmd_fifo_*        - FWFT command FIFO read side (64-bit)
//               dat_fifo_*        - FWFT data FIFO read side (DATA_W)
//               m_axi_aw*/w*/b*   - AXI4 write master channels
//               busy              - FSM not idle
//               burst_done        - pulse per accepted B response
//               burst_cnt         - completed bursts, wrapping
//               err_resp/len/timeout - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module rdmap_ddr_writer
  import rdmap_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [63:0]         cmd_fifo_dout,
  input  logic                cmd_fifo_empty,
  output logic                cmd_fifo_rd_en,
  input  logic [DATA_W-1:0]   dat_fifo_dout,
  input  logic                dat_fifo_empty,
  output logic                dat_fifo_rd_en,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic                busy,
  output logic                burst_done,
  output logic [15:0]         burst_cnt,
  output logic                err_resp,
  output logic                err_len,
  output logic                err_timeout
);

  localparam int                c_WD_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYC - 1);

  wr_state_e           r_state;
  wr_state_e           w_next_state;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [7:0]          r_awlen;
  logic [7:0]          r_beat;
  logic [c_WD_W-1:0]   r_wd;
  logic [15:0]         r_burst_cnt;
  logic                r_burst_done;
  logic                r_err_resp;
  logic                r_err_len;
  logic                r_err_timeout;

  logic [ADDR_W-1:0]   w_dec_addr;
  logic [7:0]          w_dec_awlen;
  logic                w_dec_legal;
  logic                w_cmd_pop;
  logic                w_aw_hs;
  logic                w_wvalid;
  logic                w_w_hs;
  logic                w_wlast;
  logic                w_b_hs;
  logic                w_progress;
  logic                w_timeout;

  rdmap_cmd_decode #(
    .ADDR_W (ADDR_W)
  ) u_cmd_decode (
    .i_cmd   (cmd_fifo_dout),
    .o_addr  (w_dec_addr),
    .o_awlen (w_dec_awlen),
    .o_legal (w_dec_legal)
  );

  assign w_aw_hs    = (r_state == AW) && m_axi_awready;
  assign w_wvalid   = (r_state == W) && !dat_fifo_empty;
  assign w_w_hs     = w_wvalid && m_axi_wready;
  assign w_wlast    = (r_state == W) && (r_beat == r_awlen);
  assign w_b_hs     = (r_state == B) && m_axi_bvalid;
  assign w_progress = w_aw_hs || w_w_hs || w_b_hs;
  // A handshake in the expiry cycle still wins over the abort.
  assign w_timeout  = (r_state != IDLE) && !w_progress && (r_wd == c_WD_LIMIT);

  always_comb begin
    w_next_state = r_state;
    w_cmd_pop    = 1'b0;
    case (r_state)
      IDLE: begin
        // Held off during reset so no command is lost while rst is high.
        if (!rst && !cmd_fifo_empty) begin
          w_cmd_pop = 1'b1;
          if (w_dec_legal) w_next_state = AW;
        end
      end
      AW:      if (w_aw_hs)            w_next_state = W;
      W:       if (w_w_hs && w_wlast)  w_next_state = B;
      B:       if (w_b_hs)             w_next_state = IDLE;
      default:                         w_next_state = IDLE;
    endcase
    if (w_timeout) w_next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_awaddr      <= '0;
      r_awlen       <= '0;
      r_beat        <= '0;
      r_wd          <= '0;
      r_burst_cnt   <= '0;
      r_burst_done  <= 1'b0;
      r_err_resp    <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_burst_done <= w_b_hs;

      if (w_cmd_pop && w_dec_legal) begin
        r_awaddr <= w_dec_addr;
        r_awlen  <= w_dec_awlen;
      end

      if (w_aw_hs) begin
        r_beat <= '0;
      end else if (w_w_hs) begin
        r_beat <= r_beat + 8'd1;
      end

      // Watchdog only runs while waiting on the slave with no progress.
      if ((r_state == IDLE) || w_progress || (w_next_state != r_state)) begin
        r_wd <= '0;
      end else begin
        r_wd <= r_wd + c_WD_W'(1);
      end

      if (w_b_hs) begin
        r_burst_cnt <= r_burst_cnt + 16'd1;
        if (m_axi_bresp != RESP_OKAY) r_err_resp <= 1'b1;
      end

      if (w_cmd_pop && !w_dec_legal) r_err_len     <= 1'b1;
      if (w_timeout)                 r_err_timeout <= 1'b1;
    end
  end

  assign cmd_fifo_rd_en = w_cmd_pop;
  assign dat_fifo_rd_en = w_w_hs;

  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = AXSIZE_16B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awvalid = (r_state == AW);

  assign m_axi_wdata   = (r_state == W) ? dat_fifo_dout : '0;
  assign m_axi_wstrb   = (r_state == W) ? '1 : '0;
  assign m_axi_wlast   = w_wlast;
  assign m_axi_wvalid  = w_wvalid;

  assign m_axi_bready  = (r_state == B);

  assign busy          = (r_state != IDLE);
  assign burst_done    = r_burst_done;
  assign burst_cnt     = r_burst_cnt;
  assign err_resp      = r_err_resp;
  assign err_len       = r_err_len;
  assign err_timeout   = r_err_timeout;

endmodule : rdmap_ddr_writer
`default_nettype wire

// File: tb/tb_rdmap_ddr_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rdmap_ddr_writer
// Description : Directed bench for rdmap_ddr_writer with FIFO / AXI slave
//               models and an AW / W scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rdmap_ddr_writer;

  localparam int TO = 300;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  cmd_fifo_dout;
  logic         cmd_fifo_empty;
  logic         cmd_fifo_rd_en;
  logic [127:0] dat_fifo_dout;
  logic         dat_fifo_empty;
  logic         dat_fifo_rd_en;
  logic [31:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic         m_axi_awvalid;
  logic         m_axi_awready;
  logic [127:0] m_axi_wdata;
  logic [15:0]  m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_wvalid;
  logic         m_axi_wready;
  logic [1:0]   m_axi_bresp;
  logic         m_axi_bvalid;
  logic         m_axi_bready;
  logic         busy;
  logic         burst_done;
  logic [15:0]  burst_cnt;
  logic         err_resp;
  logic         err_len;
  logic         err_timeout;

  rdmap_ddr_writer #(
    .DATA_W      (128),
    .ADDR_W      (32),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_fifo_dout  (cmd_fifo_dout),
    .cmd_fifo_empty (cmd_fifo_empty),
    .cmd_fifo_rd_en (cmd_fifo_rd_en),
    .dat_fifo_dout  (dat_fifo_dout),
    .dat_fifo_empty (dat_fifo_empty),
    .dat_fifo_rd_en (dat_fifo_rd_en),
    .m_axi_awaddr   (m_axi_awaddr),
    .m_axi_awlen    (m_axi_awlen),
    .m_axi_awsize   (m_axi_awsize),
    .m_axi_awburst  (m_axi_awburst),
    .m_axi_awvalid  (m_axi_awvalid),
    .m_axi_awready  (m_axi_awready),
    .m_axi_wdata    (m_axi_wdata),
    .m_axi_wstrb    (m_axi_wstrb),
    .m_axi_wlast    (m_axi_wlast),
    .m_axi_wvalid   (m_axi_wvalid),
    .m_axi_wready   (m_axi_wready),
    .m_axi_bresp    (m_axi_bresp),
    .m_axi_bvalid   (m_axi_bvalid),
    .m_axi_bready   (m_axi_bready),
    .busy           (busy),
    .burst_done     (burst_done),
    .burst_cnt      (burst_cnt),
    .err_resp       (err_resp),
    .err_len        (err_len),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // FIFO contents and scoreboard
  logic [63:0]  cmd_q[$];
  logic [127:0] dat_q[$];
  logic [127:0] w_exp[$];
  logic [39:0]  aw_exp[$];   // {addr, awlen}

  // Models and bookkeeping
  bit           pop_cmd, pop_dat;
  int           starve;
  int           aw_mode;     // 0 low, 1 high, 2 random
  bit           w_rand;
  bit           b_pend;
  bit           outstanding;
  int           b_count, done_cnt, bad_burst, dat_pops, w_hs_total;
  int           beat;
  logic [7:0]   cur_len;
  logic [31:0]  seq;
  bit           prev_aw_stall, prev_w_stall;
  logic [39:0]  prev_aw;
  logic [127:0] prev_wdata;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    cmd_q.delete(); dat_q.delete(); w_exp.delete(); aw_exp.delete();
    pop_cmd = 0; pop_dat = 0; starve = 0; aw_mode = 1; w_rand = 0;
    b_pend = 0; outstanding = 0; b_count = 0; done_cnt = 0; bad_burst = 0;
    dat_pops = 0; w_hs_total = 0; beat = 0; cur_len = '0;
    prev_aw_stall = 0; prev_w_stall = 0;
  endtask

  // One clock: drive model inputs after negedge, sample/check before posedge.
  task automatic tick();
    logic [39:0]  e_aw;
    logic [127:0] e_w;
    @(negedge clk);
    if (pop_cmd && cmd_q.size() > 0) void'(cmd_q.pop_front());
    if (pop_dat && dat_q.size() > 0) void'(dat_q.pop_front());
    cmd_fifo_empty = (cmd_q.size() == 0);
    cmd_fifo_dout  = cmd_fifo_empty ? 64'h0 : cmd_q[0];
    dat_fifo_empty = (dat_q.size() == 0) || (starve > 0);
    if (starve > 0) starve--;
    dat_fifo_dout  = (dat_q.size() == 0) ? 128'h0 : dat_q[0];
    m_axi_awready  = (aw_mode == 0) ? 1'b0 : (aw_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    m_axi_wready   = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axi_bvalid   = b_pend;
    m_axi_bresp    = (b_pend && (b_count + 1 == bad_burst)) ? 2'b10 : 2'b00;
    #2;
    if (burst_done) done_cnt++;
    if (cmd_fifo_rd_en) check("cmd_pop_nonempty", cmd_fifo_empty, 1'b0);
    if (dat_fifo_rd_en) begin
      check("dat_pop_nonempty", dat_fifo_empty, 1'b0);
      dat_pops++;
    end
    if (dat_fifo_rd_en || (m_axi_wvalid && m_axi_wready))
      check("dat_pop_eq_hs", dat_fifo_rd_en, m_axi_wvalid && m_axi_wready);
    if (prev_aw_stall && !err_timeout) begin
      check("aw_hold_valid", m_axi_awvalid, 1'b1);
      check("aw_hold_addr", {m_axi_awaddr, m_axi_awlen}, prev_aw);
    end
    if (prev_w_stall && !dat_fifo_empty && !err_timeout) begin
      check("w_hold_valid", m_axi_wvalid, 1'b1);
      check("w_hold_data", m_axi_wdata, prev_wdata);
    end
    if (m_axi_wvalid) check("wvalid_while_empty", dat_fifo_empty, 1'b0);
    if (m_axi_awvalid && m_axi_awready) begin
      check("aw_outstanding", outstanding, 1'b0);
      if (aw_exp.size() == 0) begin
        check("aw_unexpected", m_axi_awvalid, 1'b0);
      end else begin
        e_aw = aw_exp.pop_front();
        check("awaddr", m_axi_awaddr, e_aw[39:8]);
        check("awlen", m_axi_awlen, e_aw[7:0]);
        check("awsize_burst", {m_axi_awsize, m_axi_awburst}, 5'b10001);
        cur_len = e_aw[7:0];
      end
      outstanding = 1;
      beat = 0;
    end
    if (m_axi_wvalid && m_axi_wready) begin
      w_hs_total++;
      if (w_exp.size() == 0) begin
        check("w_unexpected", m_axi_wvalid, 1'b0);
      end else begin
        e_w = w_exp.pop_front();
        check("wdata", m_axi_wdata, e_w);
      end
      check("wstrb", m_axi_wstrb, 16'hFFFF);
      check("wlast", m_axi_wlast, (beat == int'(cur_len)));
      beat++;
      if (m_axi_wlast) b_pend = 1;
    end
    if (m_axi_bvalid && m_axi_bready) begin
      check("beats_per_burst", beat, int'(cur_len) + 1);
      b_count++;
      b_pend = 0;
      outstanding = 0;
    end
    prev_aw_stall = !rst && m_axi_awvalid && !m_axi_awready;
    prev_aw       = {m_axi_awaddr, m_axi_awlen};
    prev_w_stall  = !rst && m_axi_wvalid && !m_axi_wready;
    prev_wdata    = m_axi_wdata;
    pop_cmd = cmd_fifo_rd_en;
    pop_dat = dat_fifo_rd_en;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, busy,
                           burst_done, err_resp, err_len, err_timeout,
                           cmd_fifo_rd_en, dat_fifo_rd_en}, '0);
    check({tag, "_aw"}, {m_axi_awaddr, m_axi_awlen}, '0);
    check({tag, "_size_burst"}, {m_axi_awsize, m_axi_awburst}, 5'b10001);
    check({tag, "_wdata"}, m_axi_wdata, '0);
    check({tag, "_wstrb"}, m_axi_wstrb, '0);
    check({tag, "_cnt"}, burst_cnt, '0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs(tag);
    clear_model();
    rst = 1'b0;
  endtask

  // Legal command: base[1] doubles as the valid marker, len[3:0] must be F.
  task automatic push_burst(input logic [13:0] base, input logic [5:0] idx, input logic [11:0] len);
    logic [63:0]  c;
    logic [127:0] wd;
    int nb;
    c = '0;
    c[43:30] = base;
    c[29:24] = idx;
    c[11:0]  = len;
    cmd_q.push_back(c);
    nb = (int'(len) + 1) / 16;
    aw_exp.push_back({base, idx, 12'h000, 8'(nb - 1)});
    for (int i = 0; i < nb; i++) begin
      wd = {seq, $urandom, $urandom, $urandom};
      seq++;
      dat_q.push_back(wd);
      w_exp.push_back(wd);
    end
  endtask

  task automatic drain(input string tag, input int maxc);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    while (n < maxc && !ok) begin
      tick();
      n++;
      ok = (cmd_q.size() == 0) && (aw_exp.size() == 0) && (w_exp.size() == 0) &&
           !outstanding && !b_pend;
    end
    check(tag, ok, 1'b1);
    repeat (3) tick();
  endtask

  initial begin
    int  n;
    bit  found;
    rst = 1'b1;
    seq = 32'h1000_0000;
    cmd_fifo_dout = '0; cmd_fifo_empty = 1'b1;
    dat_fifo_dout = '0; dat_fifo_empty = 1'b1;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    clear_model();

    // Single full 4 KB burst with latency check
    do_reset("rst1");
    push_burst(14'h3E02, 6'h1F, 12'hFFF);
    n = 0; found = 0;
    while (n < 10 && !found) begin
      tick(); n++;
      found = cmd_fifo_rd_en;
    end
    check("lat_pop_seen", found, 1'b1);
    check("lat_pop_no_aw", m_axi_awvalid, 1'b0);
    tick();
    check("lat_aw_next", m_axi_awvalid, 1'b1);
    drain("p1_drain", 600);
    check("p1_cnt", burst_cnt, 16'd1);
    check("p1_done", done_cnt, 1);
    check("p1_busy", busy, 1'b0);

    // 64 back-to-back chunks
    do_reset("rst2");
    for (int i = 0; i < 64; i++) push_burst(14'h0002, 6'(i), 12'hFFF);
    drain("p2_drain", 20000);
    check("p2_cnt", burst_cnt, 16'd64);
    check("p2_done", done_cnt, 64);

    // Backpressure and data FIFO starvation
    do_reset("rst3");
    aw_mode = 2; w_rand = 1;
    push_burst(14'h1556, 6'h2A, 12'hFFF);
    n = 0; found = 0;
    while (n < 3000 && !(w_exp.size() == 0 && !outstanding && !b_pend)) begin
      if (!found && w_hs_total >= 100) begin
        starve = 10;
        found = 1;
      end
      tick(); n++;
    end
    repeat (3) tick();
    check("p3_starved", found, 1'b1);
    check("p3_pops", dat_pops, 256);
    check("p3_cnt", burst_cnt, 16'd1);

    // Error response on the third burst
    do_reset("rst4");
    bad_burst = 3;
    for (int i = 0; i < 5; i++) push_burst(14'h0006, 6'(i), 12'h03F);
    drain("p4_drain", 400);
    check("p4_err_resp", err_resp, 1'b1);
    check("p4_cnt", burst_cnt, 16'd5);
    check("p4_done", done_cnt, 5);

    // Illegal commands followed by a legal one
    do_reset("rst5");
    cmd_q.push_back(64'h0000_0000_8000_00FE);   // valid, length not beat multiple
    cmd_q.push_back(64'h0000_0000_0000_0FFF);   // valid marker clear
    push_burst(14'h0002, 6'h05, 12'h0FF);
    drain("p5_drain", 200);
    check("p5_err_len", err_len, 1'b1);
    check("p5_cnt", burst_cnt, 16'd1);
    check("p5_err_resp", err_resp, 1'b0);

    // Watchdog on a never-ready AW channel
    do_reset("rst6");
    aw_mode = 0;
    push_burst(14'h0002, 6'h01, 12'h00F);
    n = 0; found = 0;
    while (n < 10 && !found) begin
      tick(); n++;
      found = m_axi_awvalid;
    end
    check("p6_aw_seen", found, 1'b1);
    repeat (TO - 20) tick();
    check("p6_early_to", err_timeout, 1'b0);
    n = 0; found = 0;
    while (n < 60 && !found) begin
      tick(); n++;
      found = !busy;
    end
    check("p6_idle", found, 1'b1);
    check("p6_err_to", err_timeout, 1'b1);
    check("p6_awvalid", m_axi_awvalid, 1'b0);

    // Reset in the middle of a W burst, then recovery
    do_reset("rst7");
    push_burst(14'h0002, 6'h09, 12'h0FF);
    n = 0;
    while (n < 50 && beat < 4) begin
      tick(); n++;
    end
    check("p7_in_w", m_axi_wvalid, 1'b1);
    do_reset("rst_midw");
    push_burst(14'h0002, 6'h0A, 12'h07F);
    drain("p7_drain", 200);
    check("p7_cnt", burst_cnt, 16'd1);
    check("p7_errs", {err_resp, err_len, err_timeout}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rdmap_ddr_writer
`default_nettype wire
